// File: rtl/burst_mem_if.sv
// Burst address/strobe bus between the DES datapath and the byte memory responder.
// Latency: n/a (signal bundle only); reads return one cycle after the strobe.
// Backpressure: none; the responder accepts one beat every cycle.
//   master : address, write_en, read_en, wdata, clear_err out; responder status in
//   slave  : the mirror image, used by burst_mem_responder
interface burst_mem_if;
    logic [15:0] address;
    logic        write_en;
    logic        read_en;
    logic [7:0]  wdata;
    logic        clear_err;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic [63:0] block_out;
    logic        block_valid;
    logic        rd_done;
    logic        burst_busy;
    logic        burst_err;

    modport master (
        output address, write_en, read_en, wdata, clear_err,
        input  rdata, rdata_valid, block_out, block_valid, rd_done, burst_busy, burst_err
    );

    modport slave (
        input  address, write_en, read_en, wdata, clear_err,
        output rdata, rdata_valid, block_out, block_valid, rd_done, burst_busy, burst_err
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Byte memory responder for 8-beat write/read bursts; assembles each write burst into a DES block.
// Latency: write visible next cycle, read data one cycle after strobe, block/rd_done one cycle after beat 8.
// Backpressure: none; protocol violations (gaps, wrong strobe, bad address) set sticky burst_err.
//   clk, n_rst : clock and asynchronous active-low reset
//   bus        : slave side of burst_mem_if (strobes/address/wdata in, rdata/block/status out)
module burst_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int BURST_LEN = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    burst_mem_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    logic [7:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [15:0] exp_addr_q, exp_addr_d;
    logic [63:0] shift_q, shift_d;
    logic [63:0] block_out_q, block_out_d;
    logic        block_valid_q, block_valid_d;
    logic        rd_done_q, rd_done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        burst_err_q, burst_err_d;

    logic                 mem_we;
    logic                 err_set;
    logic                 collide;
    logic                 addr_ok;
    logic                 last_beat;
    logic [63:0]          shift_next;
    logic [ADDR_BITS-1:0] mem_idx;

    assign mem_idx    = bus.address[ADDR_BITS-1:0];
    assign collide    = bus.write_en & bus.read_en;
    assign addr_ok    = (bus.address == exp_addr_q);
    assign last_beat  = (beat_q == LAST_BEAT);
    assign shift_next = {shift_q[55:0], bus.wdata};

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        exp_addr_d    = exp_addr_q;
        shift_d       = shift_q;
        block_out_d   = block_out_q;
        block_valid_d = 1'b0;
        rd_done_d     = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        mem_we        = 1'b0;
        err_set       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.write_en) begin
                    // A collision here still opens a write burst; the read is dropped.
                    mem_we     = 1'b1;
                    err_set    = collide;
                    shift_d    = {56'h0, bus.wdata};
                    beat_d     = 3'd1;
                    exp_addr_d = bus.address + 16'd1;
                    state_d    = ST_WR;
                end else if (bus.read_en) begin
                    rdata_d       = mem[mem_idx];
                    rdata_valid_d = 1'b1;
                    beat_d        = 3'd1;
                    exp_addr_d    = bus.address + 16'd1;
                    state_d       = ST_RD;
                end
            end

            ST_WR: begin
                if (bus.write_en) begin
                    // Misaddressed or colliding beats are still stored and counted.
                    mem_we     = 1'b1;
                    err_set    = collide | ~addr_ok;
                    shift_d    = shift_next;
                    exp_addr_d = exp_addr_q + 16'd1;
                    if (last_beat) begin
                        block_out_d   = shift_next;
                        block_valid_d = 1'b1;
                        beat_d        = 3'd0;
                        state_d       = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else begin
                    // Gap or read-only strobe: abandon the burst, keep bytes already written.
                    err_set = 1'b1;
                    beat_d  = 3'd0;
                    state_d = ST_IDLE;
                end
            end

            ST_RD: begin
                if (bus.read_en && !bus.write_en) begin
                    rdata_d       = mem[mem_idx];
                    rdata_valid_d = 1'b1;
                    err_set       = ~addr_ok;
                    exp_addr_d    = exp_addr_q + 16'd1;
                    if (last_beat) begin
                        rd_done_d = 1'b1;
                        beat_d    = 3'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else begin
                    // Collision writes and aborts; gap or write-only strobe just aborts.
                    mem_we  = collide;
                    err_set = 1'b1;
                    beat_d  = 3'd0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                beat_d  = 3'd0;
                state_d = ST_IDLE;
            end
        endcase

        // A fresh error outranks a simultaneous clear.
        burst_err_d = (burst_err_q & ~bus.clear_err) | err_set;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            beat_q        <= 3'd0;
            exp_addr_q    <= 16'h0;
            shift_q       <= 64'h0;
            block_out_q   <= 64'h0;
            block_valid_q <= 1'b0;
            rd_done_q     <= 1'b0;
            rdata_q       <= 8'h0;
            rdata_valid_q <= 1'b0;
            burst_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            exp_addr_q    <= exp_addr_d;
            shift_q       <= shift_d;
            block_out_q   <= block_out_d;
            block_valid_q <= block_valid_d;
            rd_done_q     <= rd_done_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            burst_err_q   <= burst_err_d;
        end
    end

    // Storage is deliberately unreset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= bus.wdata;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.block_out   = block_out_q;
    assign bus.block_valid = block_valid_q;
    assign bus.rd_done     = rd_done_q;
    assign bus.burst_busy  = (state_q != ST_IDLE);
    assign bus.burst_err   = burst_err_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: directed scenarios plus random burst mix against a burst-level model.
// Latency: checks sample #1 after each rising edge.
// Backpressure: none; stimulus drives one beat per cycle.
module tb_burst_mem_responder;
    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    burst_mem_if bus_if();

    burst_mem_responder #(.ADDR_BITS(8), .BURST_LEN(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    // Burst-level reference model: byte store keyed by the low address byte, sticky error, last block.
    logic [7:0]  ref_mem   [256];
    bit          ref_known [256];
    bit          ref_err;
    logic [63:0] ref_block;
    logic [7:0]  ref_rd;
    bit          ref_rd_known;
    logic [15:0] last_wr_start;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input logic we, input logic re, input logic [15:0] a,
                       input logic [7:0] d, input logic clr);
        bus_if.write_en  = we;
        bus_if.read_en   = re;
        bus_if.address   = a;
        bus_if.wdata     = d;
        bus_if.clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic forget_mem();
        for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
        ref_rd_known = 1'b0;
    endtask

    // Write n_beats of data (first byte = data[63:56]); beat bad_beat (1..7) goes to a wrong address.
    // Fewer than 8 beats ends with a gap cycle, which must abort the burst.
    task automatic write_burst(input logic [15:0] start, input logic [63:0] data,
                               input int n_beats, input int bad_beat);
        logic [15:0] a;
        logic [7:0]  d;
        last_wr_start = start;
        for (int i = 0; i < n_beats; i++) begin
            a = start + 16'(i);
            if (i == bad_beat) begin
                a = a ^ 16'h0014;
                ref_err = 1'b1;
            end
            d = data[63 - 8*i -: 8];
            cyc(1'b1, 1'b0, a, d, 1'b0);
            ref_mem[a[7:0]]   = d;
            ref_known[a[7:0]] = 1'b1;
            if (i == 7) begin
                ref_block = data;
                check("wr_block_valid", 64'(bus_if.block_valid), 64'd1);
                check("wr_busy_end", 64'(bus_if.burst_busy), 64'd0);
            end else begin
                check("wr_no_valid", 64'(bus_if.block_valid), 64'd0);
                check("wr_busy", 64'(bus_if.burst_busy), 64'd1);
            end
            check("wr_block_out", bus_if.block_out, ref_block);
            check("wr_err", 64'(bus_if.burst_err), 64'(ref_err));
        end
        if (n_beats < 8) begin
            cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
            ref_err = 1'b1;
            check("abort_no_valid", 64'(bus_if.block_valid), 64'd0);
            check("abort_busy", 64'(bus_if.burst_busy), 64'd0);
            check("abort_err", 64'(bus_if.burst_err), 64'd1);
            check("abort_block_hold", bus_if.block_out, ref_block);
        end
    endtask

    task automatic read_burst(input logic [15:0] start);
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = start + 16'(i);
            cyc(1'b0, 1'b1, a, 8'h0, 1'b0);
            check("rd_valid", 64'(bus_if.rdata_valid), 64'd1);
            if (ref_known[a[7:0]]) check("rd_data", 64'(bus_if.rdata), 64'(ref_mem[a[7:0]]));
            check("rd_done", 64'(bus_if.rd_done), (i == 7) ? 64'd1 : 64'd0);
            check("rd_busy", 64'(bus_if.burst_busy), (i == 7) ? 64'd0 : 64'd1);
            ref_rd       = ref_mem[a[7:0]];
            ref_rd_known = ref_known[a[7:0]];
        end
        check("rd_err", 64'(bus_if.burst_err), 64'(ref_err));
    endtask

    task automatic idle_check();
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        check("idle_rvalid", 64'(bus_if.rdata_valid), 64'd0);
        check("idle_rd_done", 64'(bus_if.rd_done), 64'd0);
        check("idle_block_valid", 64'(bus_if.block_valid), 64'd0);
        check("idle_busy", 64'(bus_if.burst_busy), 64'd0);
        check("idle_err", 64'(bus_if.burst_err), 64'(ref_err));
        if (ref_rd_known) check("idle_rdata_hold", 64'(bus_if.rdata), 64'(ref_rd));
    endtask

    task automatic clear_err_cycle();
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
        ref_err = 1'b0;
        check("clear_err", 64'(bus_if.burst_err), 64'd0);
    endtask

    task automatic collide_idle(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0);
        ref_mem[a[7:0]]   = d;
        ref_known[a[7:0]] = 1'b1;
        ref_err           = 1'b1;
        check("col_no_rvalid", 64'(bus_if.rdata_valid), 64'd0);
        check("col_err", 64'(bus_if.burst_err), 64'd1);
        check("col_busy", 64'(bus_if.burst_busy), 64'd1);
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        check("col_abort_busy", 64'(bus_if.burst_busy), 64'd0);
    endtask

    initial begin
        logic [63:0] data;
        int          bad;

        ref_err   = 1'b0;
        ref_block = 64'h0;
        ref_rd    = 8'h0;
        forget_mem();
        last_wr_start = 16'h0;

        bus_if.write_en  = 1'b0;
        bus_if.read_en   = 1'b0;
        bus_if.address   = 16'h0;
        bus_if.wdata     = 8'h0;
        bus_if.clear_err = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_block_out", bus_if.block_out, 64'h0);
        check("rst_busy", 64'(bus_if.burst_busy), 64'd0);
        check("rst_err", 64'(bus_if.burst_err), 64'd0);
        check("rst_rvalid", 64'(bus_if.rdata_valid), 64'd0);
        check("rst_rdata", 64'(bus_if.rdata), 64'd0);
        n_rst = 1'b1;
        ref_rd_known = 1'b1;   // rdata is 0 out of reset and must hold

        // Basic write then read-back of the same addresses, back to back.
        write_burst(16'h0001, 64'h1122334455667788, 8, -1);
        read_burst(16'h0001);
        idle_check();

        // Non-contiguous 4th beat: sticky error, block still completes, then cleared.
        write_burst(16'h0001, 64'hA1A2A3A4A5A6A7A8, 8, 3);
        idle_check();
        clear_err_cycle();

        // Gap abort after 3 beats, then a clean burst.
        write_burst(16'h0030, 64'hC1C2C3C4C5C6C7C8, 3, -1);
        clear_err_cycle();
        write_burst(16'h0030, 64'hD1D2D3D4D5D6D7D8, 8, -1);
        read_burst(16'h0030);

        // 16-bit address wrap is contiguous.
        write_burst(16'hFFFC, 64'h0F1E2D3C4B5A6978, 8, -1);
        read_burst(16'hFFFC);
        idle_check();

        // Collision in IDLE stores the byte and drops the read.
        collide_idle(16'h0005, 8'hAB);
        clear_err_cycle();
        read_burst(16'h0001);

        // Error raised in the same cycle as clear_err wins.
        cyc(1'b1, 1'b0, 16'h0040, 8'h5A, 1'b0);
        ref_mem[8'h40] = 8'h5A; ref_known[8'h40] = 1'b1;
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
        ref_err = 1'b1;
        check("err_beats_clear", 64'(bus_if.burst_err), 64'd1);
        clear_err_cycle();

        // Opposite strobe alone aborts: read inside a write burst, write inside a read burst.
        cyc(1'b1, 1'b0, 16'h0050, 8'h66, 1'b0);
        ref_mem[8'h50] = 8'h66; ref_known[8'h50] = 1'b1;
        cyc(1'b0, 1'b1, 16'h0051, 8'h0, 1'b0);
        check("wr_rd_abort_busy", 64'(bus_if.burst_busy), 64'd0);
        check("wr_rd_abort_err", 64'(bus_if.burst_err), 64'd1);
        ref_rd_known = 1'b0;
        clear_err_cycle();
        cyc(1'b0, 1'b1, 16'h0050, 8'h0, 1'b0);
        check("rd_first_data", 64'(bus_if.rdata), 64'h66);
        cyc(1'b1, 1'b0, 16'h0051, 8'h77, 1'b0);
        ref_known[8'h51] = 1'b0;
        check("rd_wr_abort_busy", 64'(bus_if.burst_busy), 64'd0);
        check("rd_wr_abort_err", 64'(bus_if.burst_err), 64'd1);
        ref_err = 1'b1;
        ref_rd_known = 1'b0;
        clear_err_cycle();

        // Reset in the middle of a burst that already carries an error.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, (i == 2) ? 16'h0099 : 16'h0020 + 16'(i), 8'(8'h31 + i), 1'b0);
        end
        check("pre_rst_err", 64'(bus_if.burst_err), 64'd1);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_block_out", bus_if.block_out, 64'h0);
        check("mid_rst_busy", 64'(bus_if.burst_busy), 64'd0);
        check("mid_rst_err", 64'(bus_if.burst_err), 64'd0);
        check("mid_rst_rvalid", 64'(bus_if.rdata_valid), 64'd0);
        check("mid_rst_rdata", 64'(bus_if.rdata), 64'd0);
        check("mid_rst_block_valid", 64'(bus_if.block_valid), 64'd0);
        check("mid_rst_rd_done", 64'(bus_if.rd_done), 64'd0);
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        ref_err   = 1'b0;
        ref_block = 64'h0;
        forget_mem();
        idle_check();
        write_burst(16'h0020, 64'h0102030405060708, 8, -1);
        read_burst(16'h0020);

        // Random mix of bursts, back to back.
        for (int n = 0; n < 40; n++) begin
            data = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0, 1: begin
                    bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
                    write_burst(16'($urandom), data, 8, bad);
                end
                2: read_burst(last_wr_start);
                3: write_burst(16'($urandom), data, int'($urandom_range(1, 7)), -1);
                4: begin
                    read_burst(16'($urandom));
                    idle_check();
                end
                default: clear_err_cycle();
            endcase
        end
        idle_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
